// File: rtl/decode_hazard_ctrl_if.sv
// Decode-side bundle for decode_hazard_ctrl: decoded operand/destination info in,
// fetch/decode pipeline control out.
interface decode_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [2:0]       id_R_reg1;
    logic [2:0]       id_R_reg2;
    logic             id_uses_r1;
    logic             id_uses_r2;
    logic [2:0]       id_W_reg;
    logic             id_writes_reg;
    logic             id_is_load;
    logic             id_is_branch;
    logic             id_halt;
    logic             pred_wrong;
    logic             stall_fetch;
    logic             stall_decode;
    logic             bubble_ex;
    logic             flush_if;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_R_reg1, id_R_reg2, id_uses_r1, id_uses_r2,
               id_W_reg, id_writes_reg, id_is_load, id_is_branch, id_halt, pred_wrong,
        input  stall_fetch, stall_decode, bubble_ex, flush_if, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_R_reg1, id_R_reg2, id_uses_r1, id_uses_r2,
               id_W_reg, id_writes_reg, id_is_load, id_is_branch, id_halt, pred_wrong,
        output stall_fetch, stall_decode, bubble_ex, flush_if, halted, stall_cnt
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: tracks EX/MEM register writers, stalls on unresolved
// data hazards, flushes the wrong path on mispredict and drains on HALT.
module decode_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    state_t           state_q, state_d;
    logic             ex_vld_q, ex_vld_d;
    logic [2:0]       ex_reg_q, ex_reg_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_vld_q, mem_vld_d;
    logic [2:0]       mem_reg_q, mem_reg_d;
    logic             mem_load_q, mem_load_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic m_ex, m_mem, hazard_raw, hazard, run_like, issue, stall_all;

    always_comb begin
        m_ex  = ex_vld_q &
                ((bus.id_uses_r1 & (bus.id_R_reg1 == ex_reg_q)) |
                 (bus.id_uses_r2 & (bus.id_R_reg2 == ex_reg_q)));
        m_mem = mem_vld_q &
                ((bus.id_uses_r1 & (bus.id_R_reg1 == mem_reg_q)) |
                 (bus.id_uses_r2 & (bus.id_R_reg2 == mem_reg_q)));
        // Branches consume operands in decode, so forwarding cannot cover a load in MEM.
        if (FWD_EN) begin
            if (bus.id_is_branch) hazard_raw = m_ex | (m_mem & mem_load_q);
            else                  hazard_raw = m_ex & ex_load_q;
        end else begin
            hazard_raw = m_ex | m_mem;
        end
        run_like  = (state_q == RUN) || (state_q == STALL);
        hazard    = bus.id_valid & hazard_raw & run_like;
        issue     = bus.id_valid & ~hazard & run_like;
        stall_all = hazard | (state_q == HALT);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, STALL: begin
                if (hazard)                             state_d = STALL;
                else if (bus.id_valid & bus.id_halt)    state_d = HALT;
                else if (bus.id_valid & bus.pred_wrong) state_d = FLUSH;
                else                                    state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase

        ex_vld_d   = issue & bus.id_writes_reg;
        ex_reg_d   = bus.id_W_reg;
        ex_load_d  = bus.id_is_load;
        mem_vld_d  = ex_vld_q;
        mem_reg_d  = ex_reg_q;
        mem_load_d = ex_load_q;

        halted_d = (state_q == HALT) & ~ex_vld_q & ~mem_vld_q;

        stall_cnt_d = stall_cnt_q;
        if (stall_all && (state_q != HALT) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ex_vld_q    <= 1'b0;
            ex_reg_q    <= 3'd0;
            ex_load_q   <= 1'b0;
            mem_vld_q   <= 1'b0;
            mem_reg_q   <= 3'd0;
            mem_load_q  <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_vld_q    <= ex_vld_d;
            ex_reg_q    <= ex_reg_d;
            ex_load_q   <= ex_load_d;
            mem_vld_q   <= mem_vld_d;
            mem_reg_q   <= mem_reg_d;
            mem_load_q  <= mem_load_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_fetch  = stall_all;
    assign bus.stall_decode = stall_all;
    assign bus.bubble_ex    = stall_all;
    // Mispredict flush only when the branch really issues this cycle.
    assign bus.flush_if     = issue & ~bus.id_halt & bus.pred_wrong;
    assign bus.halted       = halted_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: three instances (forwarding, no forwarding,
// narrow counter) share one stimulus stream; each test checks the relevant instance.
module tb_decode_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       s_valid, s_u1, s_u2, s_wr, s_ld, s_br, s_hlt, s_pw;
    logic [2:0] s_r1, s_r2, s_w;

    always #5 clk = ~clk;

    decode_hazard_ctrl_if #(.CNT_W(16)) if1 ();
    decode_hazard_ctrl_if #(.CNT_W(16)) if0 ();
    decode_hazard_ctrl_if #(.CNT_W(4))  if4 ();

    decode_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_fwd   (.clk(clk), .rst(rst), .bus(if1));
    decode_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) dut_nofwd (.clk(clk), .rst(rst), .bus(if0));
    decode_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4))  dut_sat   (.clk(clk), .rst(rst), .bus(if4));

    assign if1.id_valid = s_valid; assign if0.id_valid = s_valid; assign if4.id_valid = s_valid;
    assign if1.id_R_reg1 = s_r1;   assign if0.id_R_reg1 = s_r1;   assign if4.id_R_reg1 = s_r1;
    assign if1.id_R_reg2 = s_r2;   assign if0.id_R_reg2 = s_r2;   assign if4.id_R_reg2 = s_r2;
    assign if1.id_uses_r1 = s_u1;  assign if0.id_uses_r1 = s_u1;  assign if4.id_uses_r1 = s_u1;
    assign if1.id_uses_r2 = s_u2;  assign if0.id_uses_r2 = s_u2;  assign if4.id_uses_r2 = s_u2;
    assign if1.id_W_reg = s_w;     assign if0.id_W_reg = s_w;     assign if4.id_W_reg = s_w;
    assign if1.id_writes_reg = s_wr; assign if0.id_writes_reg = s_wr; assign if4.id_writes_reg = s_wr;
    assign if1.id_is_load = s_ld;  assign if0.id_is_load = s_ld;  assign if4.id_is_load = s_ld;
    assign if1.id_is_branch = s_br; assign if0.id_is_branch = s_br; assign if4.id_is_branch = s_br;
    assign if1.id_halt = s_hlt;    assign if0.id_halt = s_hlt;    assign if4.id_halt = s_hlt;
    assign if1.pred_wrong = s_pw;  assign if0.pred_wrong = s_pw;  assign if4.pred_wrong = s_pw;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one decode slot, then let the combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                                 input logic u1, input logic u2, input logic [2:0] w,
                                 input logic wr, input logic ld, input logic br,
                                 input logic hlt, input logic pw);
        s_valid = v; s_r1 = r1; s_r2 = r2; s_u1 = u1; s_u2 = u2; s_w = w;
        s_wr = wr; s_ld = ld; s_br = br; s_hlt = hlt; s_pw = pw;
        #1;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        nop();
        tick();
        doReset();

        // Reset state
        nop();
        checkOutput("rst_stall_fetch", if1.stall_fetch, 0);
        checkOutput("rst_stall_decode", if1.stall_decode, 0);
        checkOutput("rst_bubble", if1.bubble_ex, 0);
        checkOutput("rst_flush", if1.flush_if, 0);
        checkOutput("rst_halted", if1.halted, 0);
        checkOutput("rst_cnt", if1.stall_cnt, 0);

        // Load-use with forwarding: one stall
        doReset();
        applyStimulus(1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 0, 0, 0);
        checkOutput("lu_ld_nostall", if1.stall_decode, 0);
        tick();
        applyStimulus(1, 3'd2, 3'd1, 1, 1, 3'd3, 1, 0, 0, 0, 0);
        checkOutput("lu_stall", if1.stall_decode, 1);
        checkOutput("lu_bubble", if1.bubble_ex, 1);
        checkOutput("lu_fetch", if1.stall_fetch, 1);
        tick();
        checkOutput("lu_issue", if1.stall_decode, 0);
        tick();
        nop();
        checkOutput("lu_cnt", if1.stall_cnt, 1);

        // ALU producer with forwarding: no stall
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd2, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd2, 3'd1, 1, 1, 3'd3, 1, 0, 0, 0, 0);
        checkOutput("alu_fwd_nostall", if1.stall_decode, 0);
        tick();

        // No forwarding: back-to-back dependency stalls twice
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd4, 3'd4, 1, 1, 3'd5, 1, 0, 0, 0, 0);
        checkOutput("nf_stall_ex", if0.stall_decode, 1);
        tick();
        checkOutput("nf_stall_mem", if0.stall_decode, 1);
        tick();
        checkOutput("nf_issue", if0.stall_decode, 0);
        tick();
        nop();
        checkOutput("nf_cnt2", if0.stall_cnt, 2);

        // No forwarding with an independent instruction between: one stall
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd1, 3'd1, 1, 1, 3'd6, 1, 0, 0, 0, 0);
        checkOutput("nf_indep", if0.stall_decode, 0);
        tick();
        applyStimulus(1, 3'd4, 3'd4, 1, 1, 3'd5, 1, 0, 0, 0, 0);
        checkOutput("nf_gap_stall", if0.stall_decode, 1);
        tick();
        checkOutput("nf_gap_issue", if0.stall_decode, 0);
        tick();
        nop();
        checkOutput("nf_cnt1", if0.stall_cnt, 1);

        // Branch on ALU result with mispredict during the hazard
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd1, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd1, 3'd0, 1, 0, 3'd0, 0, 0, 1, 0, 1);
        checkOutput("br_stall", if1.stall_decode, 1);
        checkOutput("br_noflush", if1.flush_if, 0);
        tick();
        checkOutput("br_issue", if1.stall_decode, 0);
        checkOutput("br_flush", if1.flush_if, 1);
        tick();
        nop();
        checkOutput("fl_flush0", if1.flush_if, 0);
        checkOutput("fl_fetch0", if1.stall_fetch, 0);
        checkOutput("fl_bubble0", if1.bubble_ex, 0);
        checkOutput("fl_cnt", if1.stall_cnt, 1);
        tick();

        // Branch on a load that has reached MEM still stalls with forwarding
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd3, 1, 1, 0, 0, 0);
        tick();
        nop();
        tick();
        applyStimulus(1, 3'd3, 3'd0, 1, 0, 3'd0, 0, 0, 1, 0, 0);
        checkOutput("brld_stall", if1.stall_decode, 1);
        checkOutput("brld_noflush", if1.flush_if, 0);
        tick();
        checkOutput("brld_issue", if1.stall_decode, 0);
        tick();

        // HALT with a load in EX
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd6, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);
        checkOutput("h_issue_nostall", if1.stall_fetch, 0);
        tick();
        checkOutput("h_fetch_e0", if1.stall_fetch, 1);
        checkOutput("h_halted_e0", if1.halted, 0);
        tick();
        checkOutput("h_halted_e1", if1.halted, 0);
        tick();
        checkOutput("h_halted_e2", if1.halted, 1);
        checkOutput("h_bubble", if1.bubble_ex, 1);
        tick();
        checkOutput("h_fetch_late", if1.stall_fetch, 1);
        checkOutput("h_cnt", if1.stall_cnt, 0);

        // Reset in the middle of a stall with stall_cnt=5
        doReset();
        applyStimulus(1, 3'd0, 3'd0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 3'd4, 3'd4, 1, 1, 3'd5, 1, 0, 0, 0, 0);
        tick(); tick(); tick();
        applyStimulus(1, 3'd5, 3'd5, 1, 1, 3'd6, 1, 0, 0, 0, 0);
        tick(); tick(); tick();
        applyStimulus(1, 3'd6, 3'd6, 1, 1, 3'd7, 1, 0, 0, 0, 0);
        tick();
        checkOutput("mr_cnt5", if0.stall_cnt, 5);
        checkOutput("mr_in_stall", if0.stall_decode, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mr_nostall", if0.stall_decode, 0);
        checkOutput("mr_cnt0", if0.stall_cnt, 0);
        checkOutput("mr_halted", if0.halted, 0);
        tick();

        // Saturation of a 4-bit counter over 20 load-use stalls
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 3'd1, 3'd0, 1, 0, 3'd2, 1, 1, 0, 0, 0);
            tick();
            applyStimulus(1, 3'd2, 3'd1, 1, 1, 3'd3, 1, 0, 0, 0, 0);
            tick();
            tick();
            checkOutput($sformatf("sat_%0d", i), if4.stall_cnt, (i + 1 > 15) ? 15 : i + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
